ex_ctrl_pipe: RTL and testbench
===============================

Name: ex_ctrl_pipe

Overview:
- Next-generation EX-stage control unit for the 5-stage MIPS pipeline.
- Decodes the ID-stage instruction into EX/MEM/WB control and registers it as the ID/EX control register.
- Adds bubble insertion (load-use stall), branch flush, illegal-opcode flagging and a multi-cycle MULT/DIV occupancy counter that back-pressures IF/ID.

Parameters:
- ALUOP_W, 3: ALU op field width, >=3; codes zero-extended to this width.
- MULDIV_LAT, 4: cycles a MULT/MULTU/DIV/DIVU occupies EX, >=1.
- CNT_W, 3: occupancy counter width; must hold MULDIV_LAT-1.
- ENABLE_MULDIV, 1: 0 = muldiv functs decode as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_inst  in  32  instruction in ID.
- id_valid  in  1  id_inst is a real instruction.
- stall_in  in  1  hazard unit load-use stall; inject bubble into EX.
- flush  in  1  branch/jump redirect; inject bubble into EX.
- ex_valid  out  1  EX holds a real instruction.
- ex_inst  out  32  registered instruction, for funct/rt/rd downstream.
- ex_alu_op  out  ALUOP_W  0=add, 1=sub, 2=R-type (use funct), 3=and, 4=or, 5=slt, 6=lui.
- ex_alu_src  out  1  ALU B = immediate.
- ex_imm_zext  out  1  zero-extend immediate (else sign-extend).
- ex_reg_dst  out  1  write rd (else rt).
- ex_reg_write  out  1  WB writes the register file.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_mem_to_reg  out  1  WB from memory.
- ex_branch  out  1  conditional branch.
- ex_branch_ne  out  1  branch on not-equal.
- ex_illegal  out  1  valid instruction with undecoded opcode/funct.
- ex_muldiv_start  out  1  one-cycle start pulse to the mul/div unit.
- stall_out  out  1  EX busy; freeze PC and IF/ID.

Behaviour:
- Decode is combinational from id_inst and registered into EX on the rising edge; no output is combinational from inputs.
- All control bits are forced 0 unless id_valid=1.
- Decode table, by opcode (bits 31:26):
  - 000000 R-type: alu_op=2, reg_dst, reg_write.
  - R-type, funct 011000..011011 with ENABLE_MULDIV=1: muldiv. alu_op=2, reg_dst=0, reg_write=0.
  - 100011 lw: add, alu_src, mem_read, reg_write, mem_to_reg.
  - 101011 sw: add, alu_src, mem_write.
  - 000100 beq: sub, branch.
  - 000101 bne: sub, branch, branch_ne.
  - 001000 addi: add, alu_src, reg_write.
  - 001100 andi: and, alu_src, imm_zext, reg_write.
  - 001101 ori: or, alu_src, imm_zext, reg_write.
  - 001010 slti: slt, alu_src, reg_write.
  - 001111 lui: lui, alu_src, reg_write.
  - Anything else, or muldiv functs with ENABLE_MULDIV=0: all controls 0, ex_illegal=1, ex_valid=1.
- Per-edge update, highest priority first:
  1. Hold (cnt!=0): EX register, ex_valid and ex_inst unchanged; ex_muldiv_start=0; cnt decrements. flush and stall_in are ignored; the hazard unit never redirects under an older busy muldiv.
  2. flush: bubble. ex_valid=0, all controls and ex_inst = 0.
  3. stall_in: bubble, same as flush.
  4. Otherwise: load the decode.
- Muldiv entry:
  - Loading a valid muldiv sets ex_muldiv_start=1 for exactly the following cycle and sets cnt = MULDIV_LAT-1.
  - stall_out = (cnt != 0), registered-derived.
  - The instruction occupies EX for MULDIV_LAT cycles in total.
  - MULDIV_LAT=1: no stall; start pulse only.
  - Back-to-back muldiv: the second loads on the edge where cnt returns to 0, with no gap.
- Reset (async, any time including mid-muldiv):
  - Every output to 0, cnt=0.
  - First post-reset edge loads normally.

Test Plan:
- Reset mid-operation: rst pulsed while cnt=2 -> all outputs 0 and stall_out=0 immediately without a clock edge; next edge loads id_inst.
- lw: id_inst=0x8C220004, id_valid=1, one edge -> ex_valid=1, alu_op=0, alu_src=1, mem_read=1, reg_write=1, mem_to_reg=1, others 0. Then ori 0x34220F0F -> alu_op=4, imm_zext=1, reg_write=1.
- Load-use: stall_in=1 with addi 0x20220005 in ID -> next cycle ex_valid=0, all controls 0; release stall_in -> addi decode loaded. flush and stall_in both 1 -> bubble.
- Muldiv: MULDIV_LAT=4, mult 0x00430018 loaded -> ex_muldiv_start=1 for 1 cycle; stall_out=1 for 3 cycles; EX holds 4 cycles. flush=1 asserted during hold -> ignored.
- Illegal: opcode 111111, id_valid=1 -> ex_illegal=1, ex_valid=1, controls 0. With ENABLE_MULDIV=0, mult -> ex_illegal=1, no start pulse, stall_out=0.
- Back-to-back: div then divu, MULDIV_LAT=2 -> two start pulses 2 cycles apart; stall_out high 1 cycle after each.

Source files
------------

// File: rtl/ex_ctrl_pipe.sv
// ID/EX control register: decodes the ID instruction and registers EX/MEM/WB control,
// with bubble injection on stall/flush and a MULT/DIV occupancy counter that freezes IF/ID.
module ex_ctrl_pipe #(
    parameter int ALUOP_W       = 3,
    parameter int MULDIV_LAT    = 4,
    parameter int CNT_W         = 3,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        id_inst,
    input  logic               id_valid,
    input  logic               stall_in,
    input  logic               flush,
    output logic               ex_valid,
    output logic [31:0]        ex_inst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_imm_zext,
    output logic               ex_reg_dst,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_branch,
    output logic               ex_branch_ne,
    output logic               ex_illegal,
    output logic               ex_muldiv_start,
    output logic               stall_out
);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(6);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [ALUOP_W-1:0] d_alu_op;
    logic               d_alu_src, d_imm_zext, d_reg_dst, d_reg_write;
    logic               d_mem_read, d_mem_write, d_mem_to_reg;
    logic               d_branch, d_branch_ne, d_illegal, d_muldiv;
    logic [CNT_W-1:0]   cnt;

    assign opcode = id_inst[31:26];
    assign funct  = id_inst[5:0];

    always_comb begin
        d_alu_op     = '0;
        d_alu_src    = 1'b0;
        d_imm_zext   = 1'b0;
        d_reg_dst    = 1'b0;
        d_reg_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_branch     = 1'b0;
        d_branch_ne  = 1'b0;
        d_illegal    = 1'b0;
        d_muldiv     = 1'b0;
        case (opcode)
            6'b000000: begin
                // funct 0x18..0x1B are MULT/MULTU/DIV/DIVU
                if (funct[5:2] == 4'b0110) begin
                    if (ENABLE_MULDIV != 0) begin
                        d_alu_op = ALU_R;
                        d_muldiv = 1'b1;
                    end else begin
                        d_illegal = 1'b1;
                    end
                end else begin
                    d_alu_op    = ALU_R;
                    d_reg_dst   = 1'b1;
                    d_reg_write = 1'b1;
                end
            end
            6'b100011: begin
                d_alu_op     = ALU_ADD;
                d_alu_src    = 1'b1;
                d_mem_read   = 1'b1;
                d_reg_write  = 1'b1;
                d_mem_to_reg = 1'b1;
            end
            6'b101011: begin
                d_alu_op    = ALU_ADD;
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
            end
            6'b000100: begin
                d_alu_op = ALU_SUB;
                d_branch = 1'b1;
            end
            6'b000101: begin
                d_alu_op    = ALU_SUB;
                d_branch    = 1'b1;
                d_branch_ne = 1'b1;
            end
            6'b001000: begin
                d_alu_op    = ALU_ADD;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
            end
            6'b001100: begin
                d_alu_op    = ALU_AND;
                d_alu_src   = 1'b1;
                d_imm_zext  = 1'b1;
                d_reg_write = 1'b1;
            end
            6'b001101: begin
                d_alu_op    = ALU_OR;
                d_alu_src   = 1'b1;
                d_imm_zext  = 1'b1;
                d_reg_write = 1'b1;
            end
            6'b001010: begin
                d_alu_op    = ALU_SLT;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
            end
            6'b001111: begin
                d_alu_op    = ALU_LUI;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (!id_valid) begin
            d_alu_op     = '0;
            d_alu_src    = 1'b0;
            d_imm_zext   = 1'b0;
            d_reg_dst    = 1'b0;
            d_reg_write  = 1'b0;
            d_mem_read   = 1'b0;
            d_mem_write  = 1'b0;
            d_mem_to_reg = 1'b0;
            d_branch     = 1'b0;
            d_branch_ne  = 1'b0;
            d_illegal    = 1'b0;
            d_muldiv     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid        <= 1'b0;
            ex_inst         <= '0;
            ex_alu_op       <= '0;
            ex_alu_src      <= 1'b0;
            ex_imm_zext     <= 1'b0;
            ex_reg_dst      <= 1'b0;
            ex_reg_write    <= 1'b0;
            ex_mem_read     <= 1'b0;
            ex_mem_write    <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
            ex_branch       <= 1'b0;
            ex_branch_ne    <= 1'b0;
            ex_illegal      <= 1'b0;
            ex_muldiv_start <= 1'b0;
            cnt             <= '0;
        end else if (cnt != '0) begin
            // busy muldiv owns EX; redirects cannot arrive under it
            cnt             <= cnt - 1'b1;
            ex_muldiv_start <= 1'b0;
        end else if (flush || stall_in) begin
            ex_valid        <= 1'b0;
            ex_inst         <= '0;
            ex_alu_op       <= '0;
            ex_alu_src      <= 1'b0;
            ex_imm_zext     <= 1'b0;
            ex_reg_dst      <= 1'b0;
            ex_reg_write    <= 1'b0;
            ex_mem_read     <= 1'b0;
            ex_mem_write    <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
            ex_branch       <= 1'b0;
            ex_branch_ne    <= 1'b0;
            ex_illegal      <= 1'b0;
            ex_muldiv_start <= 1'b0;
        end else begin
            ex_valid        <= id_valid;
            ex_inst         <= id_valid ? id_inst : 32'h0;
            ex_alu_op       <= d_alu_op;
            ex_alu_src      <= d_alu_src;
            ex_imm_zext     <= d_imm_zext;
            ex_reg_dst      <= d_reg_dst;
            ex_reg_write    <= d_reg_write;
            ex_mem_read     <= d_mem_read;
            ex_mem_write    <= d_mem_write;
            ex_mem_to_reg   <= d_mem_to_reg;
            ex_branch       <= d_branch;
            ex_branch_ne    <= d_branch_ne;
            ex_illegal      <= d_illegal;
            ex_muldiv_start <= d_muldiv;
            cnt             <= d_muldiv ? CNT_LOAD : '0;
        end
    end

    assign stall_out = (cnt != '0);

endmodule

// File: tb/tb_ex_ctrl_pipe.sv
// Drives four parameterisations of ex_ctrl_pipe (LAT4, LAT4 without muldiv, LAT2, LAT1)
// from shared stimulus and compares each against a table-level reference model.
module tb_ex_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] id_inst = '0;
    logic        id_valid = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;

    logic [3:0][47:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(int g);
        return (g == 2) ? 2 : (g == 3) ? 1 : 4;
    endfunction

    function automatic int en_of(int g);
        return (g == 1) ? 0 : 1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        logic        valid, alu_src, imm_zext, reg_dst, reg_write, mem_read, mem_write;
        logic        mem_to_reg, branch, branch_ne, illegal, start, stall;
        logic [31:0] inst;
        logic [2:0]  alu_op;
        ex_ctrl_pipe #(
            .ALUOP_W(3), .MULDIV_LAT(lat_of(g)), .CNT_W(3), .ENABLE_MULDIV(en_of(g))
        ) dut (
            .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
            .stall_in(stall_in), .flush(flush),
            .ex_valid(valid), .ex_inst(inst), .ex_alu_op(alu_op), .ex_alu_src(alu_src),
            .ex_imm_zext(imm_zext), .ex_reg_dst(reg_dst), .ex_reg_write(reg_write),
            .ex_mem_read(mem_read), .ex_mem_write(mem_write), .ex_mem_to_reg(mem_to_reg),
            .ex_branch(branch), .ex_branch_ne(branch_ne), .ex_illegal(illegal),
            .ex_muldiv_start(start), .stall_out(stall)
        );
        assign obs[g] = {valid, inst, alu_op, alu_src, imm_zext, reg_dst, reg_write,
                         mem_read, mem_write, mem_to_reg, branch, branch_ne, illegal,
                         start, stall};
    end

    typedef struct {
        bit        valid;
        bit [31:0] inst;
        bit [2:0]  alu;
        bit        alu_src, imm_zext, reg_dst, reg_write, mem_read, mem_write;
        bit        mem_to_reg, branch, branch_ne, illegal, start, md;
    } ex_t;

    ex_t m[4];
    int  rem[4];

    // Behavioural decode straight from the opcode table.
    function automatic ex_t decode(input bit [31:0] inst, input bit v, input int en);
        ex_t e = '{default: 0};
        if (!v) return e;
        e.valid = 1;
        e.inst  = inst;
        case (inst[31:26])
            6'h00: begin
                if (inst[5:0] >= 6'h18 && inst[5:0] <= 6'h1B) begin
                    if (en != 0) begin e.alu = 2; e.md = 1; end
                    else e.illegal = 1;
                end else begin
                    e.alu = 2; e.reg_dst = 1; e.reg_write = 1;
                end
            end
            6'h23: begin e.alu = 0; e.alu_src = 1; e.mem_read = 1; e.reg_write = 1; e.mem_to_reg = 1; end
            6'h2B: begin e.alu = 0; e.alu_src = 1; e.mem_write = 1; end
            6'h04: begin e.alu = 1; e.branch = 1; end
            6'h05: begin e.alu = 1; e.branch = 1; e.branch_ne = 1; end
            6'h08: begin e.alu = 0; e.alu_src = 1; e.reg_write = 1; end
            6'h0C: begin e.alu = 3; e.alu_src = 1; e.imm_zext = 1; e.reg_write = 1; end
            6'h0D: begin e.alu = 4; e.alu_src = 1; e.imm_zext = 1; e.reg_write = 1; end
            6'h0A: begin e.alu = 5; e.alu_src = 1; e.reg_write = 1; end
            6'h0F: begin e.alu = 6; e.alu_src = 1; e.reg_write = 1; end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic logic [47:0] pack(input ex_t e, input int r);
        return {e.valid, e.inst, e.alu, e.alu_src, e.imm_zext, e.reg_dst, e.reg_write,
                e.mem_read, e.mem_write, e.mem_to_reg, e.branch, e.branch_ne, e.illegal,
                e.start, r != 0};
    endfunction

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m[g]   = '{default: 0};
            rem[g] = 0;
        end
    endtask

    task automatic model_edge();
        for (int g = 0; g < 4; g++) begin
            if (rem[g] > 0) begin
                rem[g]--;
                m[g].start = 0;
            end else if (flush || stall_in) begin
                m[g] = '{default: 0};
            end else begin
                m[g]       = decode(id_inst, id_valid, en_of(g));
                m[g].start = m[g].md;
                rem[g]     = m[g].md ? lat_of(g) - 1 : 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int g = 0; g < 4; g++)
            check($sformatf("%s/u%0d", tag, g), obs[g], pack(m[g], rem[g]));
    endtask

    task automatic step(input logic [31:0] i, input logic v, input logic s, input logic f,
                        input string tag);
        id_inst  = i;
        id_valid = v;
        stall_in = s;
        flush    = f;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    localparam logic [31:0] LW   = 32'h8C220004;
    localparam logic [31:0] ORI  = 32'h34220F0F;
    localparam logic [31:0] ADDI = 32'h20220005;
    localparam logic [31:0] MULT = 32'h00430018;
    localparam logic [31:0] DIV  = 32'h0043001A;
    localparam logic [31:0] DIVU = 32'h0043001B;
    localparam logic [31:0] ILL  = 32'hFC000000;
    localparam logic [31:0] NOP  = 32'h00000020;

    logic [5:0]  ops [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08,
                              6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h3F, 6'h02};
    logic [5:0]  fns [7]  = '{6'h20, 6'h22, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h2A};

    initial begin
        logic [31:0] r;
        logic [31:0] ri;
        #1 rst = 1'b1;
        model_reset();
        #2 check_all("reset");
        #1 rst = 1'b0;

        // lw then ori; explicit field expectations as well as the model
        step(LW, 1, 0, 0, "lw");
        check("lw_fields", obs[0], {1'b1, LW, 3'd0, 12'b100110100000});
        step(ORI, 1, 0, 0, "ori");
        check("ori_fields", obs[0], {1'b1, ORI, 3'd4, 12'b110100000000});

        // load-use bubble, release, and both redirects together
        step(ADDI, 1, 1, 0, "stall_bubble");
        check("stall_bubble_zero", obs[0], 48'h0);
        step(ADDI, 1, 0, 0, "addi_load");
        step(ADDI, 1, 1, 1, "stall_flush_bubble");
        step(ADDI, 0, 0, 0, "invalid");

        // mult with flush asserted during the hold
        step(MULT, 1, 0, 0, "mult_load");
        check("mult_start_stall", obs[0][1:0], 48'h3);
        for (int k = 0; k < 3; k++) step(ADDI, 1, 0, 1, $sformatf("mult_hold%0d", k));
        step(ADDI, 1, 0, 0, "after_mult");
        check("after_mult_addi", obs[0][47:45] == 3'b100 ? obs[0][47:15] : 48'h0,
              {1'b1, ADDI});

        step(ILL, 1, 0, 0, "illegal");
        step(MULT, 1, 0, 0, "mult_u1");

        // back-to-back div/divu; divu waits in ID while EX is busy
        step(NOP, 1, 0, 0, "drain");
        for (int k = 0; k < 3; k++) step(NOP, 1, 0, 0, "drain");
        step(DIV, 1, 0, 0, "div");
        for (int k = 0; k < 3; k++) step(DIVU, 1, 0, 0, $sformatf("divu%0d", k));
        for (int k = 0; k < 4; k++) step(NOP, 1, 0, 0, "drain2");

        // async reset while u0 counter sits at 2
        step(MULT, 1, 0, 0, "mult_pre_rst");
        step(NOP, 1, 0, 0, "mult_cnt2");
        #1 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        check("async_rst_stall", {47'h0, obs[0][0]}, 48'h0);
        #1 rst = 1'b0;
        step(LW, 1, 0, 0, "post_rst_load");

        for (int n = 0; n < 600; n++) begin
            r  = $urandom();
            ri = $urandom();
            ri[31:26] = ops[r[3:0] % 12];
            if (ri[31:26] == 6'h00) ri[5:0] = fns[r[7:4] % 7];
            step(ri, r[11:8] != 4'h0, r[15:12] == 4'h0, r[19:16] == 4'h0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
